// File: rtl/iddr_rgmii_rx_if.sv
// RGMII receive-side bundle: DDR pad inputs from the PHY and the
// byte-stream/statistics outputs toward the MAC.
interface iddr_rgmii_rx_if #(
  parameter int FRAME_LEN_WIDTH = 16,
  parameter int ERR_COUNT_WIDTH = 16
);
  logic [3:0]                 rx_d;
  logic                       rx_ctl;
  logic                       mii_select;
  logic [7:0]                 rx_data;
  logic                       rx_valid;
  logic                       rx_er;
  logic                       rx_sof;
  logic                       rx_eof;
  logic [FRAME_LEN_WIDTH-1:0] rx_frame_len;
  logic                       rx_frame_len_valid;
  logic [ERR_COUNT_WIDTH-1:0] rx_err_count;

  modport master (
    input  rx_d, rx_ctl, mii_select,
    output rx_data, rx_valid, rx_er, rx_sof, rx_eof,
           rx_frame_len, rx_frame_len_valid, rx_err_count
  );

  modport slave (
    output rx_d, rx_ctl, mii_select,
    input  rx_data, rx_valid, rx_er, rx_sof, rx_eof,
           rx_frame_len, rx_frame_len_valid, rx_err_count
  );
endinterface

// File: rtl/iddr_rgmii_rx.sv
// RGMII receiver: DDR capture, clk-domain alignment, gigabit/nibble byte
// assembly and frame delimiting with length and bad-frame statistics.
module iddr_rgmii_rx #(
  parameter int FRAME_LEN_WIDTH = 16,
  parameter int ERR_COUNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  iddr_rgmii_rx_if.master  bus
);

  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

  // DDR capture
  logic [3:0] d_rise, d_fall;
  logic       c_rise, c_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rise <= '0;
      c_rise <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      d_rise <= bus.rx_d;
      c_rise <= bus.rx_ctl;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_fall <= '0;
      c_fall <= 1'b0;
    end else begin
      d_fall <= bus.rx_d;
      c_fall <= bus.rx_ctl;
    end
  end

  // Re-register the rise/fall pair into a single rising-edge word
  logic [3:0] nib_lo, nib_hi;
  logic       dv, er;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_lo <= '0;
      nib_hi <= '0;
      dv     <= 1'b0;
      er     <= 1'b0;
    end else begin
      nib_lo <= d_rise;
      nib_hi <= d_fall;
      dv     <= c_rise;
      er     <= c_rise ^ c_fall;
    end
  end

  state_t                     state, state_d;
  logic                       phase, phase_d;
  logic [3:0]                 hold_nib, hold_nib_d;
  logic                       hold_er, hold_er_d;
  logic [FRAME_LEN_WIDTH-1:0] byte_cnt, cnt_d;
  logic                       bad, bad_d;
  logic [FRAME_LEN_WIDTH-1:0] frame_len, len_d;
  logic [ERR_COUNT_WIDTH-1:0] err_cnt, err_cnt_d;
  logic [7:0]                 data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       er_q, er_d;
  logic                       sof_q, sof_d;
  logic                       eof_q, eof_d;

  logic [7:0] byte_data;
  logic       byte_valid, byte_er, odd_end;

  // Byte assembly: nibble mode pairs the held first nibble with the current one
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    byte_data  = {nib_hi, nib_lo};
    byte_valid = dv;
    byte_er    = er;
    if (bus.mii_select) begin
      byte_data  = {nib_lo, hold_nib};
      byte_valid = dv & phase;
      byte_er    = er | hold_er;
    end
  end

  assign odd_end = bus.mii_select & phase;

  always_comb begin
    state_d    = state;
    phase_d    = bus.mii_select & dv & ~phase;
    hold_nib_d = hold_nib;
    hold_er_d  = hold_er;
    cnt_d      = byte_cnt;
    bad_d      = bad;
    len_d      = frame_len;
    err_cnt_d  = err_cnt;
    data_d     = byte_data;
    valid_d    = 1'b0;
    er_d       = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;

    if (bus.mii_select && dv && !phase) begin
      hold_nib_d = nib_lo;
      hold_er_d  = er;
    end

    unique case (state)
      IDLE: begin
        if (byte_valid) begin
          state_d = FRAME;
          valid_d = 1'b1;
          er_d    = byte_er;
          sof_d   = 1'b1;
          cnt_d   = FRAME_LEN_WIDTH'(1);
          bad_d   = byte_er;
        end else if (!dv) begin
          er_d = er;  // carrier indication outside a frame
        end
      end
      FRAME: begin
        if (!dv) begin
          state_d = IDLE;
          eof_d   = 1'b1;
          er_d    = odd_end;
          len_d   = byte_cnt;
          if ((bad || odd_end) && err_cnt != '1) err_cnt_d = err_cnt + 1'b1;
        end else if (byte_valid) begin
          valid_d = 1'b1;
          er_d    = byte_er;
          bad_d   = bad | byte_er;
          if (byte_cnt != '1) cnt_d = byte_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= 1'b0;
      hold_nib  <= '0;
      hold_er   <= 1'b0;
      byte_cnt  <= '0;
      bad       <= 1'b0;
      frame_len <= '0;
      err_cnt   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      er_q      <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      hold_nib  <= hold_nib_d;
      hold_er   <= hold_er_d;
      byte_cnt  <= cnt_d;
      bad       <= bad_d;
      frame_len <= len_d;
      err_cnt   <= err_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      er_q      <= er_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
    end
  end

  assign bus.rx_data            = data_q;
  assign bus.rx_valid           = valid_q;
  assign bus.rx_er              = er_q;
  assign bus.rx_sof             = sof_q;
  assign bus.rx_eof             = eof_q;
  assign bus.rx_frame_len_valid = eof_q;
  assign bus.rx_frame_len       = frame_len;
  assign bus.rx_err_count       = err_cnt;

endmodule
